dac1001_ctrl: RTL
=================

Name: dac1001_ctrl

Overview:
- Digital sequencer that drives the 10-bit DAC hard macro: enable, load strobe and the 10 code bits.
- Accepts samples on a valid/ready stream into a small FIFO.
- Powers the DAC up with a warm-up delay and presents each code at a programmable sample period.
- The DAC latches its code on the falling edge of its reset pin. This block generates that edge after a defined data setup time.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of 2, at least 2.
- CLKDIV_W, 16, width of sample-period divisor.
- WARMUP_W, 8, width of warm-up counter.
- SETUP_CYC, 2, clk cycles dac_sel is stable before the dac_rst falling edge; at least 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  DAC enable request.
- clkdiv  input  CLKDIV_W  sample period in clk cycles.
- warmup  input  WARMUP_W  warm-up cycles after dac_en rises.
- s_data  input  10  sample code.
- s_valid  input  1  sample valid.
- s_ready  output  1  FIFO not full.
- fifo_clear  input  1  flush FIFO.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held.
- underflow  output  1  sticky underrun flag.
- underflow_clr  input  1  clear underflow.
- busy  output  1  state is not OFF.
- dac_en  output  1  to DAC EN.
- dac_rst  output  1  to DAC RST; its falling edge latches the code.
- dac_sel  output  10  to DAC SELD9..SELD0.

Behaviour:
- Reset values:
  - dac_en=0, dac_rst=1, dac_sel=0.
  - FIFO empty, fifo_level=0, s_ready=1.
  - underflow=0, busy=0, state OFF, primed=0.
- All DAC-facing outputs are registered and glitch-free.
- Push occurs on s_valid&&s_ready. s_ready = !full, combinational from FIFO state.
- Pop is internal. Push and pop in the same cycle leave the level unchanged.
- fifo_clear empties the FIFO next cycle. A push in the same cycle is dropped, and s_ready stays 1.
- Effective period P = max(clkdiv, SETUP_CYC+2).
  - A period counter loads P-1 at each pop and counts down to 0.
- FSM:
  - OFF: dac_en=0, dac_rst=1, dac_sel=0, primed=0. If en=1: go to WARM, set dac_en=1, load the warm-up counter with warmup.
  - WARM: counter decrements each cycle. At counter==0 go to HOLD with the period counter at 0. warmup=0 gives exactly 1 cycle in WARM.
  - HOLD: waits for period counter==0 and FIFO non-empty, then goes to SETUP.
    - If the counter reaches 0 with the FIFO empty and primed=1, set underflow on that cycle only (once per underrun).
    - Stay in HOLD until data arrives; dac_sel keeps the old value.
    - With primed=0 an empty FIFO is not an underflow.
  - SETUP: on entry pop the FIFO head into dac_sel, drive dac_rst=1, load the period counter, set primed=1. Stay SETUP_CYC cycles.
  - LATCH: dac_rst=0 (this is the falling edge), 1 cycle, then go to HOLD. dac_rst stays 0 in HOLD.
- Pop-to-pop spacing is exactly P cycles while the FIFO stays non-empty.
- en=0 in any state: next cycle go to OFF with OFF outputs. A half-finished sample is abandoned without a falling edge. FIFO contents are retained.
- underflow: set has priority over underflow_clr in the same cycle. rst clears it.
- rst mid-operation: everything returns to reset values, including the FIFO.
- Arithmetic: counters are unsigned; no wrap is possible because counters load and then decrement to 0 and stop.

Optional Feature:
- Macro: DAC1001_CTRL_IRQ_EN.
- Defined:
  - Adds input irq_level_thr [$clog2(FIFO_DEPTH):0] and output irq.
  - irq is registered: irq = underflow | (busy && fifo_level <= irq_level_thr).
  - Reset value of irq is 0.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Reset then en=1, warmup=3: dac_en rises 1 cycle after en; WARM lasts 4 cycles; dac_rst stays 1 and no underflow while the FIFO is empty.
- Push 0x3FF, 0x000, 0x155 with clkdiv=10, SETUP_CYC=2, warmup=0:
  - dac_sel shows each code 2 cycles before its dac_rst falling edge.
  - Falling edges are exactly 10 cycles apart.
- clkdiv=1 with 4 samples queued: spacing is clamped to 4 cycles.
- Push 1 sample, clkdiv=8, wait: underflow sets 8 cycles after the pop, dac_sel holds its value, and underflow is raised once only. A simultaneous underflow_clr does not clear it; a later clr does.
- Fill the FIFO with 16 samples: s_ready=0 and fifo_level=16. A 17th push is not accepted. fifo_clear gives fifo_level=0 and s_ready=1.
- en drops during SETUP: next cycle dac_en=0, dac_rst=1, dac_sel=0, with no falling edge. The remaining FIFO entries are intact; re-enable resumes with the next sample.

Source files
------------

// File: rtl/dac1001_if.sv
// dac1001_if: sample stream and DAC pin bundle for dac1001_ctrl
interface dac1001_if;
  logic [9:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       dac_en;
  logic       dac_rst;
  logic [9:0] dac_sel;
  modport master (output s_data, s_valid, input s_ready, dac_en, dac_rst, dac_sel);
  modport slave (input s_data, s_valid, output s_ready, dac_en, dac_rst, dac_sel);
endinterface

// File: rtl/dac1001_ctrl.sv
// dac1001_ctrl: sample FIFO plus warm-up/setup/latch sequencer for the 10-bit DAC macro
// Define DAC1001_CTRL_IRQ_EN to add irq_level_thr input and registered irq output.
module dac1001_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CLKDIV_W   = 16,
  parameter int WARMUP_W   = 8,
  parameter int SETUP_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [CLKDIV_W-1:0]           clkdiv,
  input  logic [WARMUP_W-1:0]           warmup,
  input  logic                          fifo_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow,
  input  logic                          underflow_clr,
  output logic                          busy,
`ifdef DAC1001_CTRL_IRQ_EN
  input  logic [$clog2(FIFO_DEPTH):0]   irq_level_thr,
  output logic                          irq,
`endif
  dac1001_if.slave                      bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(SETUP_CYC + 1);
  localparam logic [CLKDIV_W-1:0] MIN_P = CLKDIV_W'(SETUP_CYC + 2);
  typedef enum logic [2:0] {OFF, WARM, HOLD, SETUP, LATCH} state_t;
  state_t state_q, state_d;
  logic [WARMUP_W-1:0] wcnt_q, wcnt_d;
  logic [CLKDIV_W-1:0] pcnt_q, pcnt_d, per_m1;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [9:0] mem [FIFO_DEPTH];
  logic [9:0] dac_sel_q, dac_sel_d;
  logic primed_q, primed_d, uf_seen_q, uf_seen_d, underflow_q, underflow_d;
  logic dac_en_q, dac_en_d, dac_rst_q, dac_rst_d;
  logic push, pop, empty, full, uf_set;
  assign fifo_level = wr_q - rd_q;
  assign empty = wr_q == rd_q;
  assign full = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign push = bus.s_valid && !full && !fifo_clear;
  assign wr_d = fifo_clear ? '0 : wr_q + {{AW{1'b0}}, push};
  assign rd_d = fifo_clear ? '0 : rd_q + {{AW{1'b0}}, pop};
  assign per_m1 = (clkdiv > MIN_P ? clkdiv : MIN_P) - CLKDIV_W'(1);
  assign underflow_d = uf_set | (underflow_q & !underflow_clr);
  assign busy = state_q != OFF;
  assign underflow = underflow_q;
  assign bus.s_ready = !full;
  assign bus.dac_en = dac_en_q;
  assign bus.dac_rst = dac_rst_q;
  assign bus.dac_sel = dac_sel_q;
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    scnt_d = scnt_q;
    pcnt_d = (pcnt_q != '0) ? pcnt_q - CLKDIV_W'(1) : pcnt_q;
    primed_d = primed_q;
    uf_seen_d = uf_seen_q;
    uf_set = 1'b0;
    pop = 1'b0;
    dac_en_d = dac_en_q;
    dac_rst_d = dac_rst_q;
    dac_sel_d = dac_sel_q;
    // dropping en abandons any sample in flight without producing a falling edge
    if (!en) begin
      state_d = OFF;
      dac_en_d = 1'b0;
      dac_rst_d = 1'b1;
      dac_sel_d = '0;
      primed_d = 1'b0;
      uf_seen_d = 1'b0;
      pcnt_d = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = WARM;
          dac_en_d = 1'b1;
          wcnt_d = warmup;
        end
        WARM: begin
          state_d = (wcnt_q == '0) ? HOLD : WARM;
          wcnt_d = (wcnt_q == '0) ? wcnt_q : wcnt_q - WARMUP_W'(1);
          pcnt_d = '0;
        end
        HOLD: if (pcnt_q == '0) begin
          if (!empty) begin
            state_d = SETUP;
            pop = 1'b1;
            dac_sel_d = mem[rd_q[AW-1:0]];
            dac_rst_d = 1'b1;
            pcnt_d = per_m1;
            scnt_d = SW'(SETUP_CYC - 1);
            primed_d = 1'b1;
            uf_seen_d = 1'b0;
          end else if (primed_q && !uf_seen_q) begin
            uf_set = 1'b1;
            uf_seen_d = 1'b1;
          end
        end
        SETUP: begin
          state_d = (scnt_q == '0) ? LATCH : SETUP;
          dac_rst_d = scnt_q != '0;
          scnt_d = (scnt_q == '0) ? scnt_q : scnt_q - SW'(1);
        end
        LATCH: state_d = HOLD;
        default: state_d = OFF;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= bus.s_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      wcnt_q <= '0;
      pcnt_q <= '0;
      scnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      primed_q <= 1'b0;
      uf_seen_q <= 1'b0;
      underflow_q <= 1'b0;
      dac_en_q <= 1'b0;
      dac_rst_q <= 1'b1;
      dac_sel_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      pcnt_q <= pcnt_d;
      scnt_q <= scnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      primed_q <= primed_d;
      uf_seen_q <= uf_seen_d;
      underflow_q <= underflow_d;
      dac_en_q <= dac_en_d;
      dac_rst_q <= dac_rst_d;
      dac_sel_q <= dac_sel_d;
    end
  end
`ifdef DAC1001_CTRL_IRQ_EN
  logic irq_q, irq_d;
  assign irq_d = underflow_q | (busy && fifo_level <= irq_level_thr);
  assign irq = irq_q;
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else irq_q <= irq_d;
  end
`endif
endmodule
